midi_rx_fifo: RTL and testbench

MIDI serial receiver with a byte FIFO. It converts the 31250-baud MIDI input line into bytes and buffers them for the processor. The processor drains the FIFO through memory-mapped loads, so the block sits directly upstream of the CPU's data-memory read path. Framing and overrun conditions are reported as sticky flags.

---
 rtl/midi_rx_fifo_pkg.sv | 23 ++
 rtl/byte_fifo.sv | 61 ++++++
 rtl/midi_rx_fifo.sv | 120 ++++++++++++
 tb/tb_midi_rx_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/midi_rx_fifo_pkg.sv
// Shared definitions for the MIDI receiver: FSM state encodings, default bit
// timing, MMIO addresses and the serial shift helper.
package midi_rx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam int MIDI_CLKS_PER_BIT = 1600;

  localparam logic [31:0] MIDI_ADDR_DATA   = 32'h1000_0040;
  localparam logic [31:0] MIDI_ADDR_STATUS = 32'h1000_0044;

  // MIDI is LSB-first: new bits enter at the top and walk down to bit 0.
  function automatic logic [7:0] shift_in_lsb(input logic [7:0] sr, input logic b);
    return {b, sr[7:1]};
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO; resolves simultaneous push/pop at the full and empty
// boundaries internally.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  import midi_rx_fifo_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(DEPTH));
    do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/midi_rx_fifo.sv
// MIDI serial receiver: synchroniser, framing FSM and sticky error flags in
// front of a show-ahead byte FIFO read by the CPU.
module midi_rx_fifo #(
  parameter int CLKS_PER_BIT = 1600,
  parameter int DEPTH        = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx,
  input  logic                     pop,
  input  logic                     clear_err,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     frame_err
);
  import midi_rx_fifo_pkg::*;

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] HALF_BIT = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_BIT = BW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q, sync_d;
  logic          rx_s;
  rx_state_e     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          stop_tick, fifo_push, frame_bad;
  logic          fifo_full, fifo_empty;

  always_comb begin
    sync_d      = {sync_q[0], rx};
    rx_s        = sync_q[1];
    stop_tick   = (state_q == ST_STOP) && (baud_q == '0);
    fifo_push   = stop_tick & rx_s;
    frame_bad   = stop_tick & ~rx_s;
    // A set in the same cycle as clear_err takes priority.
    overrun_d   = (fifo_push & fifo_full & ~pop) | (overrun_q & ~clear_err);
    frame_err_d = frame_bad | (frame_err_q & ~clear_err);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q      <= 2'b11;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            baud_q  <= HALF_BIT;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_q != '0) begin
            baud_q <= baud_q - 1'b1;
          end else if (!rx_s) begin
            baud_q    <= FULL_BIT;
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (baud_q != '0) begin
            baud_q <= baud_q - 1'b1;
          end else begin
            shift_q   <= shift_in_lsb(shift_q, rx_s);
            baud_q    <= FULL_BIT;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (baud_q != '0) baud_q <= baud_q - 1'b1;
          else              state_q <= rx_s ? ST_IDLE : ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (rx_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (pop),
    .din   (shift_q),
    .dout  (rx_data),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid  = ~fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_midi_rx_fifo.sv
// Directed and randomised frames against a queue-based reference of the
// MIDI receiver FIFO.
module tb_midi_rx_fifo;
  import midi_rx_fifo_pkg::*;

  localparam int C = 16;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       pop = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] count;
  logic       overrun;
  logic       frame_err;

  midi_rx_fifo #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .pop       (pop),
    .clear_err (clear_err),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .count     (count),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  logic [7:0] q[$];
  bit         m_ovr = 0;
  bit         m_ferr = 0;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] head;
    head = (q.size() > 0) ? q[0] : 8'h00;
    check({tag, ".valid"}, 32'(rx_valid), 32'(q.size() > 0));
    check({tag, ".data"},  32'(rx_data), 32'(head));
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".ovr"},   32'(overrun), 32'(m_ovr));
    check({tag, ".ferr"},  32'(frame_err), 32'(m_ferr));
  endtask

  task automatic check_state(input string tag, input rx_state_e exp);
    check(tag, 32'(dut.state_q), 32'(exp));
  endtask

  // Drives one 10-bit frame starting at a falling clock edge; optionally pops
  // in the very cycle the receiver pushes the byte.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit pop_at_push);
    bit popped = 0;
    for (int i = 0; i < 10; i++) begin
      rx = (i == 0) ? 1'b0 : (i == 9) ? stop_ok : b[i-1];
      for (int k = 0; k < C; k++) begin
        if (pop_at_push && !popped && dut.fifo_push) begin
          pop = 1'b1;
          popped = 1;
        end else begin
          pop = 1'b0;
        end
        @(negedge clock);
      end
    end
    pop = 1'b0;
    if (pop_at_push) check("pop_sync", 32'(popped), 32'd1);
    if (!stop_ok) begin
      m_ferr = 1;
    end else begin
      if (popped && q.size() > 0) void'(q.pop_front());
      if (q.size() < D) q.push_back(b);
      else m_ovr = 1;
    end
  endtask

  task automatic do_pop();
    pop = 1'b1;
    @(negedge clock);
    pop = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    m_ovr = 0;
    m_ferr = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    m_ovr = 0;
    m_ferr = 0;
  endtask

  initial begin
    logic [7:0] b;
    @(negedge clock);
    do_reset();
    check_all("reset");
    check_state("reset_state", ST_IDLE);

    // Single byte, then pop
    send_frame(8'h90, 1, 0);
    check_all("single");
    do_pop();
    check_all("single_pop");

    // Back-to-back bytes, popped in order
    send_frame(8'h90, 1, 0);
    send_frame(8'h3C, 1, 0);
    send_frame(8'h7F, 1, 0);
    check_all("b2b");
    repeat (3) begin
      do_pop();
      check_all("b2b_pop");
    end

    // Overflow drops the fifth byte
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1, 0);
    check_all("ovf");
    do_clear();
    check_all("ovf_clr");
    repeat (4) begin
      do_pop();
      check_all("ovf_pop");
    end

    // Pop coinciding with a push into a full FIFO
    for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 1, 0);
    send_frame(8'hC5, 1, 1);
    check_all("full_pp");
    repeat (4) begin
      do_pop();
      check_all("full_pp_pop");
    end

    // Short glitch is ignored
    send_frame(8'h21, 1, 0);
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (30) @(negedge clock);
    check_all("glitch");
    check_state("glitch_state", ST_IDLE);

    // Framing error, then break held low
    send_frame(8'h55, 0, 0);
    check_all("ferr");
    repeat (2 * C) @(negedge clock);
    check_state("wait_idle", ST_WAIT_IDLE);
    rx = 1'b1;
    repeat (5) @(negedge clock);
    check_state("wait_idle_exit", ST_IDLE);
    check_all("ferr_after");
    do_clear();
    check_all("ferr_clr");

    // Reset in DATA bit 3 of a frame of ones
    rx = 1'b0;
    repeat (C) @(negedge clock);
    rx = 1'b1;
    repeat (3 * C + C / 2) @(negedge clock);
    check_state("mid_data", ST_DATA);
    do_reset();
    check_all("mid_reset");
    check_state("mid_reset_state", ST_IDLE);
    repeat (6 * C) @(negedge clock);
    send_frame(8'hF8, 1, 0);
    check_all("post_reset");
    do_pop();

    // Randomised frames with random pops and occasional clears
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(255, 0));
      send_frame(b, 1, 0);
      check_all("rnd_rx");
      for (int p = 0; p < int'($urandom_range(2, 0)); p++) begin
        do_pop();
        check_all("rnd_pop");
      end
      if ($urandom_range(3, 0) == 0) begin
        do_clear();
        check_all("rnd_clr");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
